// File: rtl/cpu_inta_sequencer.sv
// CPU-side PIC interrupt-acknowledge sequencer: runs the two-pulse INTA handshake to
// capture the vector, and writes OCW2 EOI commands back to the PIC on handler completion.
module cpu_inta_sequencer #(
    parameter int unsigned INTA_LOW_CYCLES = 2,
    parameter int unsigned GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_req,
    input  logic       if_enable,
    input  logic [7:0] data_in,
    output logic       inta_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ack,
    input  logic       isr_done,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       wr_n,
    output logic       a0,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic       eoi_overrun
);

    localparam int unsigned CNT_MAX = (INTA_LOW_CYCLES > GAP_CYCLES) ? INTA_LOW_CYCLES : GAP_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LOW_LOAD = CW'(INTA_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INTA1  = 3'd1,
        S_GAP    = 3'd2,
        S_INTA2  = 3'd3,
        S_HOLD   = 3'd4,
        S_EOI_WR = 3'd5
    } state_t;

    // OCW2 EOI command byte: specific EOI carries the IR level, otherwise non-specific 8'h20.
    function automatic logic [7:0] ocw2_eoi(input logic specific, input logic [2:0] level);
        if (specific) begin
            return {3'b011, 2'b00, level};
        end else begin
            return 8'h20;
        end
    endfunction

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          sync1_q;
    logic          sync2_q;
    logic          pending_q;
    logic          spec_q;
    logic [2:0]    lvl_q;
    logic          overrun_q;
    logic          inta_n_q;
    logic          wr_n_q;
    logic          a0_q;
    logic          data_oe_q;
    logic [7:0]    data_out_q;
    logic [7:0]    vector_q;
    logic          vector_valid_q;
    logic          busy_q;
    logic          eoi_done_s;

    assign eoi_done_s = (state_q == S_EOI_WR) && (cnt_q == '0);

    // Two-flop synchroniser for the asynchronous PIC INT line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= int_req;
            sync2_q <= sync1_q;
        end
    end

    // EOI request latch: first request's parameters win until the write completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            spec_q    <= 1'b0;
            lvl_q     <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            if (isr_done && pending_q) begin
                overrun_q <= 1'b1;
            end else if (isr_done) begin
                spec_q <= eoi_specific;
                lvl_q  <= eoi_level;
            end else begin
                overrun_q <= overrun_q;
            end
            if (eoi_done_s) begin
                pending_q <= 1'b0;
            end else if (isr_done) begin
                pending_q <= 1'b1;
            end else begin
                pending_q <= pending_q;
            end
        end
    end

    // Sequencer FSM with all bus strobes registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            inta_n_q       <= 1'b1;
            wr_n_q         <= 1'b1;
            a0_q           <= 1'b0;
            data_oe_q      <= 1'b0;
            data_out_q     <= 8'h00;
            vector_q       <= 8'h00;
            vector_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            a0_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pending_q) begin
                        state_q    <= S_EOI_WR;
                        cnt_q      <= LOW_LOAD;
                        wr_n_q     <= 1'b0;
                        data_oe_q  <= 1'b1;
                        data_out_q <= ocw2_eoi(spec_q, lvl_q);
                        busy_q     <= 1'b1;
                    end else if (sync2_q && if_enable) begin
                        state_q  <= S_INTA1;
                        cnt_q    <= LOW_LOAD;
                        inta_n_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_INTA1: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_GAP;
                        cnt_q    <= GAP_LOAD;
                        inta_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_INTA2;
                        cnt_q    <= LOW_LOAD;
                        inta_n_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_INTA2: begin
                    // The PIC drives the vector during this pulse; take it on the last low cycle.
                    if (cnt_q == '0) begin
                        state_q        <= S_HOLD;
                        inta_n_q       <= 1'b1;
                        vector_q       <= data_in;
                        vector_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (vector_ack) begin
                        state_q        <= S_IDLE;
                        vector_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                    end else begin
                        vector_valid_q <= 1'b1;
                    end
                end
                S_EOI_WR: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_IDLE;
                        wr_n_q     <= 1'b1;
                        data_oe_q  <= 1'b0;
                        data_out_q <= 8'h00;
                        busy_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q        <= S_IDLE;
                    cnt_q          <= '0;
                    inta_n_q       <= 1'b1;
                    wr_n_q         <= 1'b1;
                    data_oe_q      <= 1'b0;
                    data_out_q     <= 8'h00;
                    vector_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign inta_n       = inta_n_q;
    assign wr_n         = wr_n_q;
    assign a0           = a0_q;
    assign data_oe      = data_oe_q;
    assign data_out     = data_out_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;
    assign busy         = busy_q;
    assign eoi_overrun  = overrun_q;

endmodule

// File: tb/tb_cpu_inta_sequencer.sv
// Self-checking bench for cpu_inta_sequencer: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a timeline-based model.
module tb_cpu_inta_sequencer;

    localparam int L = 2;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       int_req = 1'b0;
    logic       if_enable = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       vector_ack = 1'b0;
    logic       isr_done = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       inta_n;
    logic [7:0] vector;
    logic       vector_valid;
    logic       wr_n;
    logic       a0;
    logic [7:0] data_out;
    logic       data_oe;
    logic       busy;
    logic       eoi_overrun;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cpu_inta_sequencer #(.INTA_LOW_CYCLES(L), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .int_req(int_req), .if_enable(if_enable),
        .data_in(data_in), .inta_n(inta_n), .vector(vector), .vector_valid(vector_valid),
        .vector_ack(vector_ack), .isr_done(isr_done), .eoi_specific(eoi_specific),
        .eoi_level(eoi_level), .wr_n(wr_n), .a0(a0), .data_out(data_out),
        .data_oe(data_oe), .busy(busy), .eoi_overrun(eoi_overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the current activity (0 idle, 1 acknowledge, 2 holding vector, 3 EOI write)
    // and the cycle it began; strobe levels follow from the elapsed cycle count.
    int         cyc;
    int         m_act;
    int         m_t0;
    bit         m_s1, m_s2, m_pend, m_spec, m_ovr;
    bit   [2:0] m_lvl;
    bit   [7:0] m_vec;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; m_act <= 0; m_t0 <= 0; m_s1 <= 1'b0; m_s2 <= 1'b0;
            m_pend <= 1'b0; m_spec <= 1'b0; m_lvl <= 3'd0; m_ovr <= 1'b0; m_vec <= 8'h00;
        end else begin
            cyc <= cyc + 1;
            case (m_act)
                0: begin
                    if (m_pend) begin
                        m_act <= 3; m_t0 <= cyc + 1;
                    end else if (m_s2 && if_enable) begin
                        m_act <= 1; m_t0 <= cyc + 1;
                    end
                end
                1: if (cyc - m_t0 == 2 * L + G - 1) begin m_act <= 2; m_vec <= data_in; end
                2: if (vector_ack) m_act <= 0;
                3: if (cyc - m_t0 == L - 1) m_act <= 0;
                default: m_act <= 0;
            endcase
            if (m_act == 3 && cyc - m_t0 == L - 1) m_pend <= 1'b0;
            else if (isr_done) m_pend <= 1'b1;
            if (isr_done && !m_pend) begin m_spec <= eoi_specific; m_lvl <= eoi_level; end
            if (isr_done && m_pend) m_ovr <= 1'b1;
            m_s1 <= int_req;
            m_s2 <= m_s1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inta_n", inta_n, !(m_act == 1 && ((cyc - m_t0) < L || (cyc - m_t0) >= L + G)));
            chk("wr_n", wr_n, m_act != 3);
            chk("data_oe", data_oe, m_act == 3);
            chk("a0", a0, 1'b0);
            chk("busy", busy, m_act != 0);
            chk("vector_valid", vector_valid, m_act == 2);
            chk("eoi_overrun", eoi_overrun, m_ovr);
            chk("strobe_excl", inta_n | wr_n, 1'b1);
            if (m_act == 2) chk("vector", vector, m_vec);
            if (m_act == 3) chk("data_out", data_out, m_spec ? (8'h60 | {5'b00000, m_lvl}) : 8'h20);
        end
    end

    task automatic eoi_run(input logic spec, input logic [2:0] lvl, input logic [7:0] exp_b, input string tag);
        int nlow;
        nlow = 0;
        @(negedge clk);
        isr_done = 1'b1; eoi_specific = spec; eoi_level = lvl;
        @(negedge clk);
        isr_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!wr_n) begin
                if (nlow == 0) begin
                    chk({tag, "_data_out"}, data_out, exp_b);
                    chk({tag, "_a0"}, a0, 1'b0);
                end
                nlow++;
            end
        end
        chk({tag, "_wr_low_cycles"}, nlow, 2);
    endtask

    logic [8:1] pat;
    int first_inta;

    initial begin
        pat = 8'b00110011;
        repeat (3) @(negedge clk);
        chk("rst_inta_n", inta_n, 1'b1);
        chk("rst_wr_n", wr_n, 1'b1);
        chk("rst_vector", vector, 8'h00);
        chk("rst_vvalid", vector_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_oe", data_oe, 1'b0);
        chk("rst_overrun", eoi_overrun, 1'b0);
        rst_n = 1'b1;

        // Basic acknowledge: INTA low in cycles 3-4 and 7-8, vector at cycle 9.
        int_req = 1'b1; if_enable = 1'b1; data_in = 8'h45;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("t1_inta_n", inta_n, pat[i]);
        end
        @(negedge clk);
        chk("t1_vvalid", vector_valid, 1'b1);
        chk("t1_vector", vector, 8'h45);

        // Vector held stable without ack, drops the cycle after ack.
        int_req = 1'b0; data_in = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_vvalid_hold", vector_valid, 1'b1);
            chk("t2_vector_hold", vector, 8'h45);
        end
        vector_ack = 1'b1;
        @(negedge clk);
        vector_ack = 1'b0;
        chk("t2_vvalid_drop", vector_valid, 1'b0);
        repeat (3) @(negedge clk);

        eoi_run(1'b0, 3'd7, 8'h20, "t3_nonspec");
        eoi_run(1'b1, 3'd5, 8'h65, "t3_spec");

        // EOI takes priority over a simultaneous request; second isr_done overruns.
        int_req = 1'b1; isr_done = 1'b1; eoi_specific = 1'b0;
        @(negedge clk);
        isr_done = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
        @(negedge clk);
        isr_done = 1'b0;
        chk("t4_wr_n", wr_n, 1'b0);
        chk("t4_data_out", data_out, 8'h20);
        chk("t4_overrun", eoi_overrun, 1'b1);
        vector_ack = 1'b1;
        first_inta = -1;
        for (int t = 3; t <= 20; t++) begin
            @(negedge clk);
            if (!inta_n && first_inta < 0) first_inta = t;
        end
        chk("t4_first_inta", first_inta, 5);
        int_req = 1'b0;
        repeat (20) @(negedge clk);
        vector_ack = 1'b0;

        // Interrupts disabled: no acknowledge until if_enable rises.
        if_enable = 1'b0; int_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_inta_blocked", inta_n, 1'b1);
            chk("t5_busy", busy, 1'b0);
        end
        if_enable = 1'b1;
        @(negedge clk);
        chk("t5_inta_next_edge", inta_n, 1'b0);

        // Async reset during INTA2, then a fresh sequence with int_req still high.
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_inta_async", inta_n, 1'b1);
        chk("t6_vvalid", vector_valid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t6_restart_inta", inta_n, pat[i]);
        end
        vector_ack = 1'b1; int_req = 1'b0;
        repeat (20) @(negedge clk);
        vector_ack = 1'b0;

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) int_req = ~int_req;
            if_enable    = ($urandom_range(0, 9) != 0);
            data_in      = 8'($urandom);
            vector_ack   = ($urandom_range(0, 2) == 0);
            isr_done     = ($urandom_range(0, 11) == 0);
            eoi_specific = 1'($urandom);
            eoi_level    = 3'($urandom);
            if (n % 800 == 799) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_rst_inta", inta_n, 1'b1);
                chk("rnd_rst_wr", wr_n, 1'b1);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        isr_done = 1'b0; int_req = 1'b0; vector_ack = 1'b1;
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
